// File: rtl/flash_boot_pkg.sv
// Shared types and constants for the flash-to-RAM boot copy engine.
package flash_boot_pkg;
    localparam int IDX_W = 20;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;
    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // Byte address of a word; wraps modulo 2^32 by construction.
    function automatic logic [WB_AW-1:0] word_addr(input logic [WB_AW-1:0] base,
                                                   input logic [IDX_W-1:0] idx);
        return base + {{(WB_AW-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction
endpackage

// File: rtl/wb_ack_timer.sv
// Per-access ack watchdog: loads on access entry, flags the last allowed cycle.
module wb_ack_timer
    import flash_boot_pkg::*;
#(
    parameter logic [TMR_W-1:0] TIMEOUT = 8'd64
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n_i,
    input  logic load_i,
    output logic expired_o
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    // Down-counter: cycle 1 of an access holds TIMEOUT-1, cycle TIMEOUT holds zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TIMEOUT - TMR_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/flash_boot_loader.sv
// Copies WORDS words from flash to boot RAM over two Wishbone masters,
// holding the CPU in reset until the copy finishes.
//
// state | meaning
// IDLE  | one cycle after reset release
// RD    | flash read in flight
// GAP   | both buses idle one cycle so a stale flash ack can clear
// WR    | RAM write in flight
// DONE  | copy complete, CPU released
// ERR   | ack timeout, CPU held in reset
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter logic [WB_AW-1:0] SRC_BASE = 32'h0000_0000,
    parameter logic [WB_AW-1:0] DST_BASE = 32'h0000_0000,
    parameter logic [IDX_W-1:0] WORDS    = 20'd1024,
    parameter logic [TMR_W-1:0] TIMEOUT  = 8'd64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    output logic [WB_AW-1:0] fl_adr_o,
    input  logic [WB_DW-1:0] fl_dat_i,
    output logic [WB_SW-1:0] fl_sel_o,
    output logic             fl_we_o,
    output logic             fl_cyc_o,
    output logic             fl_stb_o,
    input  logic             fl_ack_i,
    output logic [WB_AW-1:0] ram_adr_o,
    output logic [WB_DW-1:0] ram_dat_o,
    output logic [WB_SW-1:0] ram_sel_o,
    output logic             ram_we_o,
    output logic             ram_cyc_o,
    output logic             ram_stb_o,
    input  logic             ram_ack_i,
    output logic             cpu_rst_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WB_DW-1:0] csum_o
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic [WB_DW-1:0] buf_q, buf_d;
    logic [WB_DW-1:0] csum_q, csum_d;
    logic             fl_cyc_q, fl_cyc_d;
    logic [WB_AW-1:0] fl_adr_q, fl_adr_d;
    logic             ram_cyc_q, ram_cyc_d;
    logic [WB_AW-1:0] ram_adr_q, ram_adr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             tmr_load;
    logic             tmr_expired;
    logic             fl_ack_ok;

    wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .load_i    (tmr_load),
        .expired_o (tmr_expired)
    );

    // The first RD cycle may still see an ack left over from the slave's previous cycle.
    assign fl_ack_ok = fl_cyc_q && !first_q && fl_ack_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        first_d   = 1'b0;
        buf_d     = buf_q;
        csum_d    = csum_q;
        fl_cyc_d  = fl_cyc_q;
        fl_adr_d  = fl_adr_q;
        ram_cyc_d = ram_cyc_q;
        ram_adr_d = ram_adr_q;
        done_d    = done_q;
        err_d     = err_q;
        cpu_rst_d = cpu_rst_q;
        tmr_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d  = ST_RD;
                idx_d    = '0;
                fl_cyc_d = 1'b1;
                fl_adr_d = word_addr(SRC_BASE, '0);
                first_d  = 1'b1;
                tmr_load = 1'b1;
            end
            ST_RD: begin
                if (fl_ack_ok) begin
                    buf_d    = fl_dat_i;
                    csum_d   = csum_q + fl_dat_i;
                    fl_cyc_d = 1'b0;
                    state_d  = ST_GAP;
                end else if (tmr_expired) begin
                    fl_cyc_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_ERR;
                end
            end
            ST_GAP: begin
                ram_cyc_d = 1'b1;
                ram_adr_d = word_addr(DST_BASE, idx_q);
                tmr_load  = 1'b1;
                state_d   = ST_WR;
            end
            ST_WR: begin
                if (ram_ack_i) begin
                    ram_cyc_d = 1'b0;
                    if (idx_q == WORDS - IDX_W'(1)) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        fl_cyc_d = 1'b1;
                        fl_adr_d = word_addr(SRC_BASE, idx_q + IDX_W'(1));
                        first_d  = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = ST_RD;
                    end
                end else if (tmr_expired) begin
                    ram_cyc_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_ERR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            first_q   <= 1'b0;
            buf_q     <= '0;
            csum_q    <= '0;
            fl_cyc_q  <= 1'b0;
            fl_adr_q  <= '0;
            ram_cyc_q <= 1'b0;
            ram_adr_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            buf_q     <= buf_d;
            csum_q    <= csum_d;
            fl_cyc_q  <= fl_cyc_d;
            fl_adr_q  <= fl_adr_d;
            ram_cyc_q <= ram_cyc_d;
            ram_adr_q <= ram_adr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign fl_adr_o  = fl_adr_q;
    assign fl_sel_o  = {WB_SW{fl_cyc_q}};
    assign fl_we_o   = 1'b0;
    assign fl_cyc_o  = fl_cyc_q;
    assign fl_stb_o  = fl_cyc_q;
    assign ram_adr_o = ram_adr_q;
    assign ram_dat_o = buf_q;
    assign ram_sel_o = {WB_SW{ram_cyc_q}};
    assign ram_we_o  = ram_cyc_q;
    assign ram_cyc_o = ram_cyc_q;
    assign ram_stb_o = ram_cyc_q;
    assign cpu_rst_o = cpu_rst_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign csum_o    = csum_q;
endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: reactive flash/RAM slaves plus a timeline model
// built from per-word ack latencies.
module tb_flash_boot_loader;
    localparam logic [31:0] SRC = 32'hFFFF_FFF8;
    localparam logic [31:0] DST = 32'h8000_0100;
    localparam int          NW  = 4;
    localparam int          T   = 24;

    logic        clk;
    logic        rst_n;
    logic [31:0] fl_adr_o, fl_dat_i, ram_adr_o, ram_dat_o, csum_o;
    logic [3:0]  fl_sel_o, ram_sel_o;
    logic        fl_we_o, fl_cyc_o, fl_stb_o, fl_ack_i;
    logic        ram_we_o, ram_cyc_o, ram_stb_o, ram_ack_i;
    logic        cpu_rst_o, done_o, err_o;

    flash_boot_loader #(
        .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(20'd4), .TIMEOUT(8'd24)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .fl_adr_o(fl_adr_o), .fl_dat_i(fl_dat_i), .fl_sel_o(fl_sel_o), .fl_we_o(fl_we_o),
        .fl_cyc_o(fl_cyc_o), .fl_stb_o(fl_stb_o), .fl_ack_i(fl_ack_i),
        .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_sel_o(ram_sel_o), .ram_we_o(ram_we_o),
        .ram_cyc_o(ram_cyc_o), .ram_stb_o(ram_stb_o), .ram_ack_i(ram_ack_i),
        .cpu_rst_o(cpu_rst_o), .done_o(done_o), .err_o(err_o), .csum_o(csum_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fc;
        logic [31:0] fa;
        logic        rc;
        logic [31:0] ra;
        logic [31:0] rd;
        logic        dn;
        logic        er;
        logic        cr;
        logic [31:0] cs;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat_f [NW];
    int          lat_r [NW];
    logic [31:0] dat_w [NW];
    int          wr_first [NW];
    int          f_rd_cnt [NW];
    int          f_dur [NW];
    bit          stale_en;
    bit          run_active;
    logic        rst_at_edge;
    exp_t        exp_q[$];
    exp_t        ce;
    logic [31:0] ew_a[$], ew_d[$];
    logic [31:0] wa_log[$], wd_log[$], fa_log[$];
    logic [31:0] exp_csum;
    bit          exp_err;
    int          exp_nrd;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int widx(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] d;
        d = (a - base) >> 2;
        return (d < 32'(NW)) ? int'(d) : 0;
    endfunction

    always_ff @(posedge clk) rst_at_edge <= rst_n;

    // Flash slave: ack from cycle lat_f of an access until cyc drops, optionally one stale cycle.
    initial begin
        int  w, f_cnt;
        bit  f_ack, f_prev;
        f_cnt = 0; f_ack = 0; f_prev = 0;
        fl_ack_i = 1'b0;
        fl_dat_i = '0;
        forever begin
            @(negedge clk);
            if (fl_cyc_o === 1'b1) begin
                w = widx(fl_adr_o, SRC);
                if (!f_prev) begin
                    f_cnt = 0;
                    f_rd_cnt[w]++;
                    fa_log.push_back(fl_adr_o);
                end
                f_cnt++;
                f_dur[w] = f_cnt;
                f_ack = (f_cnt >= lat_f[w]);
                fl_dat_i = f_ack ? dat_w[w] : $urandom();
            end else begin
                f_ack = stale_en && f_prev && f_ack;
                fl_dat_i = $urandom();
            end
            fl_ack_i = f_ack;
            f_prev = (fl_cyc_o === 1'b1);
        end
    end

    // RAM slave: same ack shape; logs every write the master should be completing.
    initial begin
        int  w, r_cnt;
        bit  r_ack, r_prev;
        r_cnt = 0; r_ack = 0; r_prev = 0;
        ram_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_cyc_o === 1'b1) begin
                w = widx(ram_adr_o, DST);
                if (!r_prev) r_cnt = 0;
                r_cnt++;
                r_ack = (r_cnt >= lat_r[w]);
                if (r_ack) begin
                    wa_log.push_back(ram_adr_o);
                    wd_log.push_back(ram_dat_o);
                end
            end else begin
                r_ack = stale_en && r_prev && r_ack;
            end
            ram_ack_i = r_ack;
            r_prev = (ram_cyc_o === 1'b1);
        end
    end

    // Expected per-cycle outputs from release onward, derived from access durations.
    task automatic build_expected();
        exp_t        e;
        logic [31:0] cs, bf;
        int          acc;
        bit          er;
        cs = '0; bf = '0; er = 0; exp_nrd = 0;
        exp_q.delete(); ew_a.delete(); ew_d.delete();
        e = '{fc:1'b0, fa:32'h0, rc:1'b0, ra:32'h0, rd:32'h0, dn:1'b0, er:1'b0, cr:1'b1, cs:32'h0};
        for (int w = 0; w < NW; w++) begin
            exp_nrd++;
            e = '{fc:1'b1, fa:SRC + 32'(w) * 4, rc:1'b0, ra:32'h0, rd:bf,
                  dn:1'b0, er:1'b0, cr:1'b1, cs:cs};
            acc = (lat_f[w] < 2) ? 2 : lat_f[w];
            if (acc > T) begin acc = T; er = 1; end
            repeat (acc) exp_q.push_back(e);
            if (er) break;
            bf = dat_w[w];
            cs = cs + bf;
            e.fc = 1'b0; e.rd = bf; e.cs = cs;
            exp_q.push_back(e);
            wr_first[w] = exp_q.size() + 1;
            e.rc = 1'b1; e.ra = DST + 32'(w) * 4;
            acc = lat_r[w];
            if (acc > T) begin acc = T; er = 1; end
            repeat (acc) exp_q.push_back(e);
            if (er) break;
            ew_a.push_back(e.ra);
            ew_d.push_back(bf);
        end
        e.fc = 1'b0; e.rc = 1'b0; e.dn = !er; e.er = er; e.cr = er;
        repeat (4) exp_q.push_back(e);
        exp_csum = cs;
        exp_err  = er;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_at_edge === 1'b0) begin
                chk("rst_fl_cyc", fl_cyc_o, 0);
                chk("rst_fl_stb", fl_stb_o, 0);
                chk("rst_fl_sel", fl_sel_o, 0);
                chk("rst_fl_adr", fl_adr_o, 0);
                chk("rst_ram_cyc", ram_cyc_o, 0);
                chk("rst_ram_stb", ram_stb_o, 0);
                chk("rst_ram_we", ram_we_o, 0);
                chk("rst_ram_sel", ram_sel_o, 0);
                chk("rst_ram_adr", ram_adr_o, 0);
                chk("rst_ram_dat", ram_dat_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_err", err_o, 0);
                chk("rst_cpu_rst", cpu_rst_o, 1);
                chk("rst_csum", csum_o, 0);
            end else if (run_active && exp_q.size() > 0) begin
                ce = exp_q.pop_front();
                chk("fl_cyc", fl_cyc_o, ce.fc);
                chk("fl_stb", fl_stb_o, ce.fc);
                chk("fl_we", fl_we_o, 0);
                if (ce.fc) begin
                    chk("fl_adr", fl_adr_o, ce.fa);
                    chk("fl_sel", fl_sel_o, 4'hf);
                end
                chk("ram_cyc", ram_cyc_o, ce.rc);
                chk("ram_stb", ram_stb_o, ce.rc);
                if (ce.rc) begin
                    chk("ram_adr", ram_adr_o, ce.ra);
                    chk("ram_dat", ram_dat_o, ce.rd);
                    chk("ram_sel", ram_sel_o, 4'hf);
                    chk("ram_we", ram_we_o, 1);
                end
                chk("done", done_o, ce.dn);
                chk("err", err_o, ce.er);
                chk("cpu_rst", cpu_rst_o, ce.cr);
                chk("csum", csum_o, ce.cs);
                chk("cyc_excl", fl_cyc_o & ram_cyc_o, 0);
            end
        end
    end

    task automatic run_copy(input int abort_w);
        int c, abort_c;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        build_expected();
        abort_c = (abort_w >= 0) ? wr_first[abort_w] + 1 : 0;
        wa_log.delete(); wd_log.delete(); fa_log.delete();
        for (int w = 0; w < NW; w++) begin
            f_rd_cnt[w] = 0;
            f_dur[w] = 0;
        end
        rst_n = 1'b1;
        run_active = 1'b1;
        c = 0;
        while (exp_q.size() > 0 && c < 2000) begin
            @(negedge clk);
            c++;
            if (abort_c > 0 && c == abort_c) begin
                rst_n = 1'b0;
                @(negedge clk);
                break;
            end
        end
        run_active = 1'b0;
        exp_q.delete();
    endtask

    task automatic post_check();
        chk("end_done", done_o, !exp_err);
        chk("end_err", err_o, exp_err);
        chk("end_cpu_rst", cpu_rst_o, exp_err);
        chk("end_csum", csum_o, exp_csum);
        chk("wr_count", wa_log.size(), ew_a.size());
        for (int i = 0; i < wa_log.size() && i < ew_a.size(); i++) begin
            chk("wr_adr", wa_log[i], ew_a[i]);
            chk("wr_dat", wd_log[i], ew_d[i]);
        end
        for (int w = 0; w < NW; w++) chk("rd_once", f_rd_cnt[w], (w < exp_nrd) ? 1 : 0);
    endtask

    task automatic set_lat(input int lf, input int lr);
        for (int w = 0; w < NW; w++) begin
            lat_f[w] = lf;
            lat_r[w] = lr;
        end
    endtask

    initial begin
        logic [31:0] fa_lit [NW];
        logic [31:0] d_lit [NW];
        rst_n = 1'b0;
        run_active = 1'b0;
        stale_en = 1'b0;
        set_lat(2, 1);
        fa_lit = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        d_lit  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        dat_w  = d_lit;

        // Slow flash, stale acks on both buses, address wrap on the third word.
        stale_en = 1'b1;
        set_lat(21, 3);
        run_copy(-1);
        post_check();
        chk("model_csum_pin", exp_csum, 32'hAAAA_AAAA);
        chk("csum_lit", csum_o, 32'hAAAA_AAAA);
        chk("done_lit", done_o, 1);
        chk("cpu_rst_lit", cpu_rst_o, 0);
        chk("fa_count", fa_log.size(), NW);
        for (int i = 0; i < NW && i < fa_log.size(); i++) chk("fa_lit", fa_log[i], fa_lit[i]);
        for (int i = 0; i < NW && i < wa_log.size(); i++) begin
            chk("wa_lit", wa_log[i], 32'h8000_0100 + 32'(i) * 4);
            chk("wd_lit", wd_log[i], d_lit[i]);
        end

        // Flash never acks the third word.
        set_lat(4, 2);
        lat_f[2] = 1000;
        run_copy(-1);
        post_check();
        chk("err_time", f_dur[2], T);
        chk("err_writes", wa_log.size(), 2);
        chk("err_csum_lit", csum_o, 32'h3333_3333);
        chk("err_lit", err_o, 1);

        // Reset during the second word's write, then a clean restart.
        stale_en = 1'b0;
        set_lat(5, 6);
        run_copy(1);
        run_copy(-1);
        post_check();
        chk("restart_first_adr", (fa_log.size() > 0) ? fa_log[0] : 32'hDEAD_0000, SRC);

        // Ack lands in the same cycle as the timeout.
        stale_en = 1'b1;
        set_lat(T, T);
        run_copy(-1);
        post_check();
        chk("edge_done", done_o, 1);

        // RAM ack one cycle too late.
        set_lat(3, 3);
        lat_r[0] = T + 1;
        run_copy(-1);
        post_check();
        chk("ram_to_err", err_o, 1);
        chk("ram_to_writes", wa_log.size(), 0);

        // Fastest slaves: flash ack offered in the ignored first cycle.
        set_lat(1, 1);
        run_copy(-1);
        post_check();

        for (int r = 0; r < 20; r++) begin
            stale_en = 1'($urandom_range(0, 1));
            for (int w = 0; w < NW; w++) begin
                dat_w[w] = $urandom();
                lat_f[w] = $urandom_range(1, T);
                lat_r[w] = $urandom_range(1, T);
            end
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) lat_f[$urandom_range(0, NW - 1)] = T + 1;
                else                           lat_r[$urandom_range(0, NW - 1)] = T + 1;
            end
            run_copy(-1);
            post_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flash_boot_loader.md
FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 Parameter SRC_BASE, default 32'h0000_0000, byte address of the first flash word to copy.
REQ-002 Parameter DST_BASE, default 32'h0000_0000, byte address of the first RAM word written.
REQ-003 Parameter WORDS, default 20'd1024, number of 32-bit words copied; legal range 1..2^20-1.
REQ-004 Parameter TIMEOUT, default 8'd64, maximum cycles waited for any ack.
REQ-005 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-006 wb_rst_n_i  in  1  reset, synchronous and active-low.
REQ-007 fl_adr_o  out  32 / fl_dat_i  in  32 / fl_sel_o  out  4 / fl_we_o  out  1 / fl_cyc_o, fl_stb_o  out  1 / fl_ack_i  in  1 -- Wishbone master toward the flash slave, read-only.
REQ-008 ram_adr_o  out  32 / ram_dat_o  out  32 / ram_sel_o  out  4 / ram_we_o  out  1 / ram_cyc_o, ram_stb_o  out  1 / ram_ack_i  in  1 -- Wishbone master toward boot RAM, write-only.
REQ-009 cpu_rst_o  out  1  active-high CPU reset, held until the copy completes.
REQ-010 done_o  out  1  copy completed without error.
REQ-011 err_o  out  1  copy aborted on ack timeout.
REQ-012 csum_o  out  32  running sum modulo 2^32 of all words read.

Function
REQ-013 FSM states: IDLE, RD, GAP, WR, DONE, ERR; all outputs registered.
REQ-014 IDLE lasts exactly one cycle after reset release, then enters RD with idx=0.
REQ-015 RD: fl_cyc_o=fl_stb_o=1, fl_we_o=0, fl_sel_o=4'hf, fl_adr_o=SRC_BASE+(idx<<2), held stable until ack.
REQ-016 fl_ack_i is ignored in the first cycle of each RD entry; it is qualified only while fl_cyc_o=1.
REQ-017 On qualified fl_ack_i: latch fl_dat_i into a 32-bit buffer, add it to csum_o, deassert fl_cyc_o/fl_stb_o at the same edge, go to GAP.
REQ-018 GAP lasts exactly one cycle with both buses idle, giving the slave time to clear a stale ack, then enters WR.
REQ-019 WR: ram_cyc_o=ram_stb_o=ram_we_o=1, ram_sel_o=4'hf, ram_adr_o=DST_BASE+(idx<<2), ram_dat_o=buffer.
REQ-020 On ram_ack_i in WR: deassert the RAM strobes at that edge; if idx==WORDS-1 go to DONE, else idx+1 and go to RD.
REQ-021 Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
REQ-022 Per-access timer resets on entering RD or WR and increments each cycle; reaching TIMEOUT without a qualified ack drops all strobes and enters ERR.
REQ-023 DONE is terminal: done_o=1, cpu_rst_o=0, buses idle.
REQ-024 ERR is terminal: err_o=1, cpu_rst_o=1, buses idle, csum_o frozen.
REQ-025 An ack that arrives in the same cycle as the timeout wins; it is treated as a successful access.
REQ-026 Acks received in any state other than the matching RD or WR are ignored.
REQ-027 The block never asserts fl_cyc_o and ram_cyc_o in the same cycle.

Reset
REQ-028 When wb_rst_n_i=0 at a clock edge: state=IDLE, idx=0, timer=0, csum_o=0, buffer=0, all cyc/stb/we=0, addresses and data=0, sel=0, done_o=0, err_o=0, cpu_rst_o=1.
REQ-029 Reset asserted mid-access aborts immediately: strobes are low at the next edge and the copy restarts from idx=0 after release.

Structure
REQ-030 Shared package flash_boot_pkg holds the FSM state encoding, word-index width (20), and Wishbone width constants.
REQ-031 One sub-module, wb_ack_timer: loadable counter plus comparator that flags when TIMEOUT is reached; it is instantiated once.

Verification
REQ-032 WORDS=4, flash model with ~21-cycle latency returning 32'h11111111,22222222,33333333,44444444 -> RAM receives them at DST_BASE+0,4,8,C; csum_o=32'hAAAAAAAA; done_o=1; cpu_rst_o falls.
REQ-033 Flash model holds ack high for one cycle after cyc drops -> no duplicate read; each flash address is read exactly once.
REQ-034 Flash never acks on the 3rd word -> ERR exactly TIMEOUT cycles after RD entry; err_o=1, cpu_rst_o=1, 2 RAM writes total.
REQ-035 wb_rst_n_i pulsed low during word 2's WR -> strobes low at the next edge; after release the copy restarts at SRC_BASE and completes normally.
REQ-036 SRC_BASE=32'hFFFF_FFFC, WORDS=2 -> second read at 32'h0000_0000.
REQ-037 Ack and timeout in the same cycle -> access accepted, no ERR.
